// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit (ROL, ASL, LSL, LSR) with valid/ready handshakes.
// Define SEQ_SHIFT_DUAL_STEP_EN to apply two single-bit steps per cycle while shifting.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a command
// SHIFT | working register moves one (or two) bit positions per cycle
// DONE  | out_valid=1, result and flags held until out_ready
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       oppshift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             carry,
  output logic             overflow
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_ASL = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [AMT_W-1:0] amt_sat;
  logic [WIDTH+1:0] st1;
`ifdef SEQ_SHIFT_DUAL_STEP_EN
  logic [WIDTH+1:0] st2;
`endif

  // Out-of-range amounts only exist when WIDTH is not a power of two.
  if ((1 << AMT_W) > WIDTH) begin : g_sat
    always_comb amt_sat = (amt > AMT_W'(WIDTH-1)) ? AMT_W'(WIDTH-1) : amt;
  end else begin : g_nosat
    assign amt_sat = amt;
  end

  // One single-bit step: returns {overflow_hit, carry_out, next_value}.
  function automatic logic [WIDTH+1:0] step1(input logic [WIDTH-1:0] b,
                                             input logic [1:0]       op);
    logic [WIDTH-1:0] nb;
    logic             c;
    logic             hit;
    nb  = b;
    c   = 1'b0;
    hit = 1'b0;
    case (op)
      OP_ROL: begin
        nb = {b[WIDTH-2:0], b[WIDTH-1]};
        c  = b[WIDTH-1];
      end
      OP_ASL: begin
        nb  = {b[WIDTH-2:0], 1'b0};
        c   = b[WIDTH-1];
        hit = b[WIDTH-1] ^ b[WIDTH-2];
      end
      OP_LSL: begin
        nb = {b[WIDTH-2:0], 1'b0};
        c  = b[WIDTH-1];
      end
      default: begin
        nb = {1'b0, b[WIDTH-1:1]};
        c  = b[0];
      end
    endcase
    return {hit, c, nb};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      count_q <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      count_q <= count_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    count_d   = count_q;
    op_d      = op_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    st1       = step1(b_q, op_q);
`ifdef SEQ_SHIFT_DUAL_STEP_EN
    st2       = step1(st1[WIDTH-1:0], op_q);
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_d     = a;
          op_d    = oppshift;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          count_d = amt_sat;
          state_d = (amt_sat == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        b_d     = st1[WIDTH-1:0];
        carry_d = st1[WIDTH];
        ovf_d   = ovf_q | st1[WIDTH+1];
        count_d = count_q - AMT_W'(1);
`ifdef SEQ_SHIFT_DUAL_STEP_EN
        if (count_q > AMT_W'(1)) begin
          b_d     = st2[WIDTH-1:0];
          carry_d = st2[WIDTH];
          ovf_d   = ovf_q | st1[WIDTH+1] | st2[WIDTH+1];
          count_d = count_q - AMT_W'(2);
        end
`endif
        if (count_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Result   = b_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: directed literal cases plus randomized traffic checked
// every cycle against an arithmetic reference model.
module tb_seq_shift_unit;
  localparam int W  = 8;
  localparam int AW = 3;
`ifdef SEQ_SHIFT_DUAL_STEP_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [AW-1:0] amt;
  logic [1:0]    oppshift;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Result;
  logic          carry;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  seq_shift_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .amt(amt), .oppshift(oppshift), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-operation reference: {overflow, carry, result} of shifting av by n.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] av, input int n,
                                          input logic [1:0] op);
    logic [W-1:0] r;
    logic c, o;
    int t;
    r = av; c = 1'b0; o = 1'b0;
    if (n != 0) begin
      case (op)
        2'b00: begin r = (av << n) | (av >> (W - n)); c = av[W-n]; end
        2'b01: begin
          r = av << n; c = av[W-n];
          t = int'(av) >> (W - 1 - n);        // top n+1 bits must all agree
          o = (t != 0) && (t != ((1 << (n + 1)) - 1));
        end
        2'b10: begin r = av << n; c = av[W-n]; end
        default: begin r = av >> n; c = av[n-1]; end
      endcase
    end
    return {o, c, r};
  endfunction

  function automatic int lat(input int n);
    return DUAL ? (n + 1) / 2 : n;
  endfunction

  // Transaction-level model: 0 idle, 1 working, 2 result presented.
  int           ph = 0;
  int           wt = 0;
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0, m_o = 1'b0;
  bit           m_fresh = 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      ph <= 0; m_res <= '0; m_c <= 1'b0; m_o <= 1'b0; m_fresh <= 1'b1;
    end else begin
      case (ph)
        0: if (in_valid) begin
          {m_o, m_c, m_res} <= ref_op(a, int'(amt), oppshift);
          m_fresh <= 1'b0;
          wt      <= lat(int'(amt));
          ph      <= (lat(int'(amt)) == 0) ? 2 : 1;
        end
        1: begin
          wt <= wt - 1;
          if (wt == 1) ph <= 2;
        end
        default: if (out_ready) ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(ph == 0));
      chk("out_valid", 32'(out_valid), 32'(ph == 2));
      if (ph == 2 || (ph == 0 && m_fresh)) begin
        chk("Result", 32'(Result), 32'(m_res));
        chk("carry", 32'(carry), 32'(m_c));
        chk("overflow", 32'(overflow), 32'(m_o));
      end
    end
  end

  // Call just after a rising edge while the unit is idle; returns after the accept edge.
  task automatic issue(input logic [W-1:0] av, input logic [AW-1:0] n, input logic [1:0] op);
    a = av; amt = n; oppshift = op; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int edges);
    edges = 0;
    @(negedge clk);
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'(1));
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic lit(input string nm, input int e, input int e_exp, input logic [W-1:0] r_exp,
                     input logic c_exp, input logic o_exp);
    chk({nm, "_lat"}, 32'(e), 32'(e_exp));
    chk({nm, "_res"}, 32'(Result), 32'(r_exp));
    chk({nm, "_carry"}, 32'(carry), 32'(c_exp));
    chk({nm, "_ovf"}, 32'(overflow), 32'(o_exp));
  endtask

  initial begin
    int e;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; amt = '0; oppshift = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_result", 32'(Result), 32'(0));
    @(posedge clk); #1;

    issue(8'h96, 3'd3, 2'b00); wait_done(e);
    lit("rol96", e, DUAL ? 2 : 3, 8'hB4, 1'b0, 1'b0);
    release_res();

    issue(8'h30, 3'd2, 2'b01); wait_done(e);
    lit("asl30", e, DUAL ? 1 : 2, 8'hC0, 1'b0, 1'b1);
    release_res();

    issue(8'h81, 3'd1, 2'b11); wait_done(e);
    lit("lsr81", e, 1, 8'h40, 1'b1, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1 in_valid = 1'b1; a = 8'hFF; amt = 3'd3; oppshift = 2'b10;
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_res", 32'(Result), 32'(8'h40));
      in_valid = 1'b0;
    end
    release_res();

    issue(8'hFF, 3'd7, 2'b10); wait_done(e);
    lit("lslFF", e, DUAL ? 4 : 7, 8'h80, 1'b1, 1'b0);
    release_res();

    issue(8'h5A, 3'd0, 2'b11); wait_done(e);
    lit("amt0", e, 0, 8'h5A, 1'b0, 1'b0);
    release_res();
    chk("b2b_in_ready", 32'(in_ready), 32'(1));
    issue(8'h01, 3'd1, 2'b00); wait_done(e);
    lit("b2b_rol", e, 1, 8'h02, 1'b0, 1'b0);
    release_res();

    issue(8'hA5, 3'd6, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_res", 32'(Result), 32'(0));
    @(posedge clk); #1;
    issue(8'hC1, 3'd1, 2'b01); wait_done(e);
    lit("post_rst_asl", e, 1, 8'h82, 1'b1, 1'b0);
    release_res();

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = 1'(($urandom_range(0, 2) != 0));
      a         = 8'($urandom);
      amt       = 3'($urandom_range(0, 7));
      oppshift  = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
